// File: rtl/step_pulse_gen.sv
// step_pulse_gen
//   Step-pulse stimulus source for the step tracker. A 32-bit phase
//   accumulator adds `rate` every enabled cycle. When the sum crosses CLK_HZ
//   it emits a registered one-cycle pulse, so exactly `rate` pulses occur per
//   CLK_HZ enabled cycles. A seconds divider advances sec_count, which in
//   hybrid mode indexes a scripted rate profile that stops after 144 s.
//
// Ports
//   CLK        system clock
//   reset      synchronous, active-high reset
//   en         run enable; low freezes accumulator, divider and seconds
//   mode[1:0]  0 walk, 1 jog, 2 run, 3 hybrid profile
//   pulse      one-cycle step pulse
//   rate[7:0]  steps/s currently generated (combinational)
//   sec_count  whole seconds in current mode, saturating at 255
//   done       hybrid profile finished (sticky until restart/reset)
//
// Optional (`define STEP_PULSE_COUNT_EN)
//   pulse_total[31:0]  wrapping count of emitted pulses
//   burst              rate >= 64 (tracker high-activity threshold)
module step_pulse_gen #(
  parameter int unsigned CLK_HZ    = 100000000,
  parameter int unsigned WALK_RATE = 32,
  parameter int unsigned JOG_RATE  = 64,
  parameter int unsigned RUN_RATE  = 128
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] mode,
  output logic       pulse,
  output logic [7:0] rate,
  output logic [7:0] sec_count,
`ifdef STEP_PULSE_COUNT_EN
  output logic [31:0] pulse_total,
  output logic        burst,
`endif
  output logic       done
);

  localparam logic [31:0] HZ    = 32'(CLK_HZ);
  localparam logic [31:0] HZ_M1 = 32'(CLK_HZ - 1);
  localparam logic [7:0]  PROFILE_END = 8'd144;

  logic [31:0] acc_q, acc_d;
  logic [31:0] sec_div_q, sec_div_d;
  logic [7:0]  sec_count_q, sec_count_d;
  logic [1:0]  mode_q, mode_d;
  logic        done_q, done_d;
  logic        pulse_q, pulse_d;
  logic [32:0] sum;
`ifdef STEP_PULSE_COUNT_EN
  logic [31:0] pulse_total_q, pulse_total_d;
`endif

  // Rate selection; the hybrid profile is indexed by the elapsed second.
  always_comb begin
    rate = 8'd0;
    case (mode_q)
      2'd0: rate = 8'(WALK_RATE);
      2'd1: rate = 8'(JOG_RATE);
      2'd2: rate = 8'(RUN_RATE);
      default: begin
        case (sec_count_q)
          8'd0: rate = 8'd20;
          8'd1: rate = 8'd33;
          8'd2: rate = 8'd66;
          8'd3: rate = 8'd27;
          8'd4: rate = 8'd70;
          8'd5: rate = 8'd30;
          8'd6: rate = 8'd19;
          8'd7: rate = 8'd30;
          8'd8: rate = 8'd33;
          default: begin
            if (sec_count_q <= 8'd72)       rate = 8'd69;
            else if (sec_count_q <= 8'd78)  rate = 8'd34;
            else if (sec_count_q <= 8'd143) rate = 8'd124;
            else                            rate = 8'd0;
          end
        endcase
      end
    endcase
  end

  always_comb begin
    acc_d       = acc_q;
    sec_div_d   = sec_div_q;
    sec_count_d = sec_count_q;
    mode_d      = mode_q;
    done_d      = done_q;
    pulse_d     = 1'b0;
    sum         = {1'b0, acc_q} + {25'd0, rate};
    if (mode != mode_q) begin
      // Restart wins over the normal step and ignores en.
      mode_d      = mode;
      acc_d       = '0;
      sec_div_d   = '0;
      sec_count_d = '0;
      done_d      = 1'b0;
    end else if (en) begin
      if (sum >= {1'b0, HZ}) begin
        pulse_d = 1'b1;
        acc_d   = 32'(sum - {1'b0, HZ});
      end else begin
        acc_d   = sum[31:0];
      end
      // The boundary cycle above still used the old rate; the new second's
      // rate is picked up from the updated sec_count on the next cycle.
      if (sec_div_q == HZ_M1) begin
        sec_div_d = '0;
        if (sec_count_q != 8'hFF) sec_count_d = sec_count_q + 8'd1;
      end else begin
        sec_div_d = sec_div_q + 32'd1;
      end
      if (mode_q == 2'd3 && sec_count_d >= PROFILE_END) done_d = 1'b1;
    end
  end

`ifdef STEP_PULSE_COUNT_EN
  // Counts alongside pulse so the total matches the pulses already seen.
  always_comb begin
    pulse_total_d = pulse_total_q + {31'd0, pulse_d};
    if (mode != mode_q) pulse_total_d = '0;
  end
`endif

  always_ff @(posedge CLK) begin
    if (reset) begin
      acc_q         <= '0;
      sec_div_q     <= '0;
      sec_count_q   <= '0;
      mode_q        <= mode;
      done_q        <= 1'b0;
      pulse_q       <= 1'b0;
`ifdef STEP_PULSE_COUNT_EN
      pulse_total_q <= '0;
`endif
    end else begin
      acc_q         <= acc_d;
      sec_div_q     <= sec_div_d;
      sec_count_q   <= sec_count_d;
      mode_q        <= mode_d;
      done_q        <= done_d;
      pulse_q       <= pulse_d;
`ifdef STEP_PULSE_COUNT_EN
      pulse_total_q <= pulse_total_d;
`endif
    end
  end

  assign pulse     = pulse_q;
  assign sec_count = sec_count_q;
  assign done      = done_q;
`ifdef STEP_PULSE_COUNT_EN
  assign pulse_total = pulse_total_q;
  assign burst       = (rate >= 8'd64);
`endif

endmodule
